// File: rtl/alarm_pkg.sv
// Shared types and default constants for the alarm controller.
// Used by alarm_controller and edge_detector.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SOUNDING = 2'd1,
    ST_SILENCED = 2'd2,
    ST_LOCKOUT  = 2'd3
  } alarm_state_e;

  localparam int BLINK_HALF_DEF    = 4;
  localparam int SOUND_TIMEOUT_DEF = 32;
  localparam int MAX_EVENTS_DEF    = 3;

  localparam logic [3:0] CNT_SAT = 4'd15;

  // Event counter increment that holds at its terminal value instead of wrapping.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    logic [3:0] r;
    if (v == CNT_SAT) begin
      r = v;
    end else begin
      r = v + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/edge_detector.sv
// Rising-edge detector: one-cycle trigger when alarme goes high.
// History clears to 0 on reset, so a level high at release counts as an edge.
module edge_detector
  import alarm_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic alarme,
  output logic trigger
);

  logic prev_r;

  // Previous-cycle sample of alarme.
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_r <= 1'b0;
    end else begin
      prev_r <= alarme;
    end
  end

  assign trigger = alarme & ~prev_r;

endmodule

// File: rtl/alarm_controller.sv
// Alarm controller: siren/LED sequencing with timeout and optional event lockout.
// Optional feature macro: ALARM_LOCKOUT_EN (event counting and LOCKOUT state).
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int BLINK_HALF    = BLINK_HALF_DEF,
  parameter int SOUND_TIMEOUT = SOUND_TIMEOUT_DEF,
  parameter int MAX_EVENTS    = MAX_EVENTS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       alarme,
  input  logic       arm,
  input  logic       ack,
  output logic       sirene,
  output logic       led_alarme,
  output logic [3:0] contagem,
  output logic       lockout
);

  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int TW = (SOUND_TIMEOUT > 1) ? $clog2(SOUND_TIMEOUT) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(SOUND_TIMEOUT - 1);

  if ((MAX_EVENTS < 1) || (MAX_EVENTS > 15)) begin : g_bad_max_events
    $error("alarm_controller: MAX_EVENTS must be in 1..15");
  end

  logic          trigger_s;
  logic          accept_s;
  logic          lock_hit_s;
  logic          timer_done_s;
  alarm_state_e  state_r;
  alarm_state_e  state_next_s;
  logic [TW-1:0] timer_r;
  logic [TW-1:0] timer_next_s;
  logic [BW-1:0] blink_r;
  logic [BW-1:0] blink_next_s;
  logic          phase_r;
  logic          phase_next_s;
  logic          sirene_r;
  logic          sirene_next_s;
  logic          led_r;
  logic          led_next_s;

  edge_detector u_edge (
    .clk     (clk),
    .reset   (reset),
    .alarme  (alarme),
    .trigger (trigger_s)
  );

  assign accept_s     = trigger_s & arm & (state_r != ST_LOCKOUT);
  assign timer_done_s = (timer_r == TIMER_LAST);

`ifdef ALARM_LOCKOUT_EN
  logic [3:0] cnt_r;
  logic       lockout_r;

  assign lock_hit_s = accept_s & (sat_inc(cnt_r) == 4'(MAX_EVENTS));

  // Accepted-trigger counter; only reset clears it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_r <= 4'd0;
    end else if (accept_s) begin
      cnt_r <= sat_inc(cnt_r);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Lockout flag follows the registered state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lockout_r <= 1'b0;
    end else begin
      lockout_r <= (state_next_s == ST_LOCKOUT);
    end
  end

  assign contagem = cnt_r;
  assign lockout  = lockout_r;
`else
  assign lock_hit_s = 1'b0;
  assign contagem   = 4'd0;
  assign lockout    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; an accepted trigger outranks ack, arm drop and timeout.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_next_s = lock_hit_s ? ST_LOCKOUT : ST_SOUNDING;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SOUNDING: begin
        if (accept_s) begin
          state_next_s = lock_hit_s ? ST_LOCKOUT : ST_SOUNDING;
        end else if (!arm || ack) begin
          state_next_s = ST_IDLE;
        end else if (timer_done_s) begin
          state_next_s = ST_SILENCED;
        end else begin
          state_next_s = ST_SOUNDING;
        end
      end
      ST_SILENCED: begin
        if (accept_s) begin
          state_next_s = lock_hit_s ? ST_LOCKOUT : ST_SOUNDING;
        end else if (!arm || ack) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_SILENCED;
        end
      end
      ST_LOCKOUT: begin
        state_next_s = ST_LOCKOUT;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Timeout and blink-phase update; any (re)entry into SOUNDING restarts both.
  always_comb begin
    timer_next_s = {TW{1'b0}};
    blink_next_s = {BW{1'b0}};
    phase_next_s = 1'b1;
    if ((state_next_s != ST_SOUNDING) || accept_s) begin
      timer_next_s = {TW{1'b0}};
      blink_next_s = {BW{1'b0}};
      phase_next_s = 1'b1;
    end else begin
      timer_next_s = timer_r + TW'(1);
      if (blink_r == BLINK_LAST) begin
        blink_next_s = {BW{1'b0}};
        phase_next_s = ~phase_r;
      end else begin
        blink_next_s = blink_r + BW'(1);
        phase_next_s = phase_r;
      end
    end
  end

  // Timer and blink registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      timer_r <= {TW{1'b0}};
      blink_r <= {BW{1'b0}};
      phase_r <= 1'b1;
    end else begin
      timer_r <= timer_next_s;
      blink_r <= blink_next_s;
      phase_r <= phase_next_s;
    end
  end

  // Output decode from the upcoming state so outputs align with the state register.
  always_comb begin
    sirene_next_s = 1'b0;
    led_next_s    = 1'b0;
    case (state_next_s)
      ST_IDLE: begin
        sirene_next_s = 1'b0;
        led_next_s    = 1'b0;
      end
      ST_SOUNDING: begin
        sirene_next_s = phase_next_s;
        led_next_s    = 1'b1;
      end
      ST_SILENCED: begin
        sirene_next_s = 1'b0;
        led_next_s    = 1'b1;
      end
      ST_LOCKOUT: begin
        sirene_next_s = 1'b1;
        led_next_s    = 1'b1;
      end
      default: begin
        sirene_next_s = 1'b0;
        led_next_s    = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sirene_r <= 1'b0;
      led_r    <= 1'b0;
    end else begin
      sirene_r <= sirene_next_s;
      led_r    <= led_next_s;
    end
  end

  assign sirene     = sirene_r;
  assign led_alarme = led_r;

endmodule

// File: tb/tb_alarm_controller.sv
// Self-checking bench for alarm_controller: a behavioural model fills an expected
// queue per cycle, DUT samples fill an observed queue, each test drains and compares.
module tb_alarm_controller;

  localparam int BH  = 2;
  localparam int TO  = 8;
  localparam int MAX = 3;
`ifdef ALARM_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_SOUND = 1;
  localparam int M_SIL   = 2;
  localparam int M_LOCK  = 3;

  typedef struct packed {
    logic       sirene;
    logic       led;
    logic [3:0] cnt;
    logic       lock;
  } obs_t;

  logic       clk;
  logic       reset;
  logic       alarme;
  logic       arm;
  logic       ack;
  logic       sirene;
  logic       led_alarme;
  logic [3:0] contagem;
  logic       lockout;

  int checks = 0;
  int errors = 0;

  obs_t exp_q[$];
  obs_t act_q[$];

  int   m_st   = M_IDLE;
  logic m_prev = 1'b0;
  int   m_age  = 0;
  int   m_cnt  = 0;

  alarm_controller #(
    .BLINK_HALF    (BH),
    .SOUND_TIMEOUT (TO),
    .MAX_EVENTS    (MAX)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .alarme     (alarme),
    .arm        (arm),
    .ack        (ack),
    .sirene     (sirene),
    .led_alarme (led_alarme),
    .contagem   (contagem),
    .lockout    (lockout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs, advance the model, then sample the DUT after the edge.
  task automatic step(input logic al, input logic ar, input logic ak, input logic rs);
    logic trig;
    logic acc;
    obs_t e;
    alarme = al;
    arm    = ar;
    ack    = ak;
    reset  = rs;
    if (!rs) begin
      m_st   = M_IDLE;
      m_prev = 1'b0;
      m_age  = 0;
      m_cnt  = 0;
    end else begin
      trig   = al & ~m_prev;
      m_prev = al;
      acc    = trig & ar & (m_st != M_LOCK);
      if (acc) begin
        if (LOCK_EN && (m_cnt < 15)) m_cnt = m_cnt + 1;
        m_st  = (LOCK_EN && (m_cnt == MAX)) ? M_LOCK : M_SOUND;
        m_age = 0;
      end else if (m_st == M_SOUND) begin
        if (!ar || ak) m_st = M_IDLE;
        else if (m_age + 1 >= TO) m_st = M_SIL;
        else m_age = m_age + 1;
      end else if (m_st == M_SIL) begin
        if (!ar || ak) m_st = M_IDLE;
      end
    end
    e.sirene = (m_st == M_SOUND) ? (((m_age / BH) % 2) == 0) : (m_st == M_LOCK);
    e.led    = (m_st != M_IDLE);
    e.cnt    = 4'(m_cnt);
    e.lock   = (m_st == M_LOCK);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    act_q.push_back({sirene, led_alarme, contagem, lockout});
  endtask

  task automatic test_reset();
    obs_t e, a;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({sirene, led_alarme, contagem, lockout} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0000000", {sirene, led_alarme, contagem, lockout});
    end
    step(1'b1, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({sirene, led_alarme} !== 2'b11) begin
      errors++;
      $display("FAIL reset_release_edge: got sirene/led %b expected 11", {sirene, led_alarme});
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL reset_seq: got %b expected %b", a, e);
      end
    end
  endtask

  task automatic test_timeout();
    obs_t e, a;
    logic [7:0] pat;
    pat = 8'b0011_0011;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step((i < 3) ? 1'b1 : 1'b0, 1'b1, 1'b0, 1'b1);
      checks++;
      if (sirene !== pat[i]) begin
        errors++;
        $display("FAIL blink_%0d: got %b expected %b", i, sirene, pat[i]);
      end
    end
    step(1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({sirene, led_alarme} !== 2'b01) begin
      errors++;
      $display("FAIL silenced: got sirene/led %b expected 01", {sirene, led_alarme});
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL timeout_seq: got %b expected %b", a, e);
      end
    end
  endtask

  task automatic test_ack();
    obs_t e, a;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({sirene, led_alarme} !== 2'b00) begin
      errors++;
      $display("FAIL ack_idle: got sirene/led %b expected 00", {sirene, led_alarme});
    end
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({sirene, led_alarme} !== 2'b11) begin
      errors++;
      $display("FAIL trig_beats_ack: got sirene/led %b expected 11", {sirene, led_alarme});
    end
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL ack_seq: got %b expected %b", a, e);
      end
    end
  endtask

  task automatic test_arm();
    obs_t e, a;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(i[0], 1'b0, 1'b0, 1'b1);
    checks++;
    if ({led_alarme, contagem} !== 5'b0) begin
      errors++;
      $display("FAIL disarmed: got led/cnt %b expected 00000", {led_alarme, contagem});
    end
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (led_alarme !== 1'b0) begin
      errors++;
      $display("FAIL arm_drop_silenced: got led %b expected 0", led_alarme);
    end
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL arm_seq: got %b expected %b", a, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, a;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    checks++;
    if (sirene !== 1'b1) begin
      errors++;
      $display("FAIL retrigger_phase: got sirene %b expected 1", sirene);
    end
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL b2b_seq: got %b expected %b", a, e);
      end
    end
  endtask

`ifdef ALARM_LOCKOUT_EN
  task automatic test_lockout();
    obs_t e, a;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int p = 0; p < 3; p++) begin
      step(1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b1);
    end
    for (int i = 0; i < 20; i++) begin
      step(i[1], i[2], 1'b1, 1'b1);
      checks++;
      if ({sirene, led_alarme, contagem, lockout} !== 7'b11_0011_1) begin
        errors++;
        $display("FAIL lockout_hold_%0d: got %b expected 1100111", i, {sirene, led_alarme, contagem, lockout});
      end
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({sirene, led_alarme, contagem, lockout} !== 7'b0) begin
      errors++;
      $display("FAIL lockout_reset: got %b expected 0000000", {sirene, led_alarme, contagem, lockout});
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL lockout_seq: got %b expected %b", a, e);
      end
    end
  endtask
`else
  task automatic test_no_lockout();
    obs_t e, a;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int p = 0; p < 5; p++) begin
      step(1'b1, 1'b1, 1'b0, 1'b1);
      checks++;
      if ({contagem, lockout, sirene} !== 6'b0000_0_1) begin
        errors++;
        $display("FAIL no_lockout_%0d: got cnt/lock/sirene %b expected 000001", p, {contagem, lockout, sirene});
      end
      step(1'b0, 1'b1, 1'b0, 1'b1);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL no_lockout_seq: got %b expected %b", a, e);
      end
    end
  endtask
`endif

  initial begin
    reset  = 1'b0;
    alarme = 1'b0;
    arm    = 1'b0;
    ack    = 1'b0;
    test_reset();
    test_timeout();
    test_ack();
    test_arm();
    test_back_to_back();
`ifdef ALARM_LOCKOUT_EN
    test_lockout();
`else
    test_no_lockout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
